// File: rtl/imem_port_arbiter.sv
// Shares the single byte-wide instruction memory port between instruction fetch
// and the program loader. Each word access is sequenced as four byte cycles.
module imem_port_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [31:0]       f_instr,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, RD3, RWAIT, WR0, WR1, WR2, WR3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              last_grant_reg, last_grant_next;  // 1 = loader won last
    logic [23:0]       bytes_reg;
    logic [31:0]       f_instr_reg;
    logic              f_valid_reg, l_done_reg;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_we_reg, mem_we_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;
    logic [1:0]        offset_next;
    logic              grant_f, grant_l;

    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        if (state_reg == IDLE && !rst) begin
            if (f_req && l_req) begin
                if (last_grant_reg) grant_f = 1'b1;
                else                grant_l = 1'b1;
            end else if (f_req) begin
                grant_f = 1'b1;
            end else if (l_req) begin
                grant_l = 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        wdata_next      = wdata_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (grant_f) begin
                    state_next      = RD0;
                    base_next       = f_addr;
                    last_grant_next = 1'b0;
                end else if (grant_l) begin
                    state_next      = WR0;
                    base_next       = l_addr;
                    wdata_next      = l_wdata;
                    last_grant_next = 1'b1;
                end
            end
            RD0:     state_next = RD1;
            RD1:     state_next = RD2;
            RD2:     state_next = RD3;
            RD3:     state_next = RWAIT;
            RWAIT:   state_next = IDLE;
            WR0:     state_next = WR1;
            WR1:     state_next = WR2;
            WR2:     state_next = WR3;
            WR3:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side outputs are computed for the upcoming state and registered,
    // so the port pins never see a combinational path from the requesters.
    always_comb begin
        offset_next    = 2'd0;
        mem_addr_next  = '0;
        mem_we_next    = 1'b0;
        mem_wdata_next = 8'h00;
        case (state_next)
            RD0, WR0: offset_next = 2'd0;
            RD1, WR1: offset_next = 2'd1;
            RD2, WR2: offset_next = 2'd2;
            RD3, WR3: offset_next = 2'd3;
            default:  offset_next = 2'd0;
        endcase
        case (state_next)
            RD0, RD1, RD2, RD3: begin
                mem_addr_next = base_next + ADDR_W'(offset_next);
            end
            WR0, WR1, WR2, WR3: begin
                mem_addr_next  = base_next + ADDR_W'(offset_next);
                mem_we_next    = 1'b1;
                mem_wdata_next = wdata_next[{offset_next, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            wdata_reg      <= 32'h0;
            last_grant_reg <= 1'b0;
            f_instr_reg    <= 32'h0;
            f_valid_reg    <= 1'b0;
            l_done_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_we_reg     <= 1'b0;
            mem_wdata_reg  <= 8'h00;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            wdata_reg      <= wdata_next;
            last_grant_reg <= last_grant_next;
            f_valid_reg    <= (state_reg == RWAIT);
            l_done_reg     <= (state_reg == WR3);
            mem_addr_reg   <= mem_addr_next;
            mem_we_reg     <= mem_we_next;
            mem_wdata_reg  <= mem_wdata_next;
            if (state_reg == RWAIT) begin
                f_instr_reg <= {mem_rdata, bytes_reg};
            end
        end
    end

    // Byte lanes 0..2 are captured in RD1..RD3; lane 3 goes straight into f_instr.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            localparam state_t CAP_STATE = state_t'(int'(RD1) + gi);
            always_ff @(posedge clk) begin
                if (rst) begin
                    bytes_reg[8*gi +: 8] <= 8'h00;
                end else if (state_reg == CAP_STATE) begin
                    bytes_reg[8*gi +: 8] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign f_gnt     = grant_f;
    assign l_gnt     = grant_l;
    assign f_valid   = f_valid_reg;
    assign f_instr   = f_instr_reg;
    assign l_done    = l_done_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a byte-wide synchronous memory model.
module tb_imem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [7:0]  f_addr;
    logic        f_gnt;
    logic        f_valid;
    logic [31:0] f_instr;
    logic        l_req;
    logic [7:0]  l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_done;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic        clear_mem;
    logic [7:0]  tmem [256];

    int errors = 0;
    int checks = 0;

    imem_port_arbiter #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_valid   (f_valid),
        .f_instr   (f_instr),
        .l_req     (l_req),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_done    (l_done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) tmem[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) tmem[mem_addr] <= mem_wdata;
            mem_rdata <= tmem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [31:0] d);
        logic [7:0] ea;
        l_req = 1'b1; l_addr = a; l_wdata = d; #1;
        chk("load_gnt", {63'd0, l_gnt}, 64'd1);
        chk("load_no_fgnt", {63'd0, f_gnt}, 64'd0);
        tick;
        l_req = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            ea = a + 8'(k);
            chk("load_we", {63'd0, mem_we}, 64'd1);
            chk("load_addr", {56'd0, mem_addr}, {56'd0, ea});
            chk("load_byte", {56'd0, mem_wdata}, {56'd0, d[8*k +: 8]});
            chk("load_no_done", {63'd0, l_done}, 64'd0);
            tick;
        end
        chk("load_done", {63'd0, l_done}, 64'd1);
        chk("load_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_fetch(input logic [7:0] a, input logic [31:0] exp);
        logic [7:0] ea;
        f_req = 1'b1; f_addr = a; #1;
        chk("fetch_gnt", {63'd0, f_gnt}, 64'd1);
        chk("fetch_no_lgnt", {63'd0, l_gnt}, 64'd0);
        tick;
        f_req = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                ea = a + 8'(k);
                chk("fetch_addr", {56'd0, mem_addr}, {56'd0, ea});
                chk("fetch_rd", {63'd0, mem_we}, 64'd0);
            end
            chk("fetch_no_valid", {63'd0, f_valid}, 64'd0);
            tick;
        end
        chk("fetch_valid", {63'd0, f_valid}, 64'd1);
        chk("fetch_instr", {32'd0, f_instr}, {32'd0, exp});
    endtask

    logic [3:0]  gnt_seq;
    int          ng;
    int          nv;
    int          ngf;
    int          last_g;
    logic        gflag;
    logic [31:0] held;
    logic [31:0] tbl [3];

    initial begin
        rst = 1'b1; clear_mem = 1'b1;
        f_req = 1'b0; f_addr = 8'h00; l_req = 1'b0; l_addr = 8'h00; l_wdata = 32'h0;
        tick; tick; tick;
        clear_mem = 1'b0;
        chk("reset_outputs",
            {10'd0, f_gnt, f_valid, f_instr, l_gnt, l_done, mem_addr, mem_we, mem_wdata, busy}, 64'd0);
        rst = 1'b0;
        tick;

        // Load then fetch
        do_load(8'h00, 32'h00500093);
        chk("mem_00", {56'd0, tmem[8'h00]}, 64'h93);
        chk("mem_01", {56'd0, tmem[8'h01]}, 64'h00);
        chk("mem_02", {56'd0, tmem[8'h02]}, 64'h50);
        chk("mem_03", {56'd0, tmem[8'h03]}, 64'h00);
        do_fetch(8'h00, 32'h00500093);

        // Wrap-around
        do_load(8'hFE, 32'hDEADBEEF);
        chk("wrap_fe", {56'd0, tmem[8'hFE]}, 64'hEF);
        chk("wrap_ff", {56'd0, tmem[8'hFF]}, 64'hBE);
        chk("wrap_00", {56'd0, tmem[8'h00]}, 64'hAD);
        chk("wrap_01", {56'd0, tmem[8'h01]}, 64'hDE);
        do_fetch(8'hFE, 32'hDEADBEEF);

        // Arbitration: both requesting from reset release
        rst = 1'b1; tick; tick;
        rst = 1'b0;
        f_req = 1'b1; f_addr = 8'h20; l_req = 1'b1; l_addr = 8'h20; l_wdata = 32'hCAFEF00D;
        #1;
        ng = 0;
        gnt_seq = 4'b0000;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            chk("arb_gnt_excl", {63'd0, f_gnt & l_gnt}, 64'd0);
            chk("arb_pulse_excl", {63'd0, f_valid & l_done}, 64'd0);
            if (f_valid) chk("arb_instr", {32'd0, f_instr}, 64'hCAFEF00D);
            if (f_gnt || l_gnt) begin
                gnt_seq[3 - ng] = l_gnt;
                ng++;
            end
            if (ng < 4) tick;
        end
        tick;
        f_req = 1'b0; l_req = 1'b0;
        chk("arb_count", 64'(ng), 64'd4);
        chk("arb_order", {60'd0, gnt_seq}, 64'hA);
        for (int c = 0; c < 8; c++) begin
            chk("arb_drain_excl", {63'd0, f_valid & l_done}, 64'd0);
            tick;
        end

        // Reset mid-write
        l_req = 1'b1; l_addr = 8'h10; l_wdata = 32'h11223344; #1;
        chk("rstw_gnt", {63'd0, l_gnt}, 64'd1);
        tick;
        l_req = 1'b0;
        tick;
        chk("rstw_in_wr1", {56'd0, mem_addr}, 64'h11);
        rst = 1'b1;
        tick;
        chk("rstw_outputs",
            {10'd0, f_gnt, f_valid, f_instr, l_gnt, l_done, mem_addr, mem_we, mem_wdata, busy}, 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("rstw_no_done", {63'd0, l_done}, 64'd0);
        end
        chk("rstw_m10", {56'd0, tmem[8'h10]}, 64'h44);
        chk("rstw_m11", {56'd0, tmem[8'h11]}, 64'h33);
        chk("rstw_m12", {56'd0, tmem[8'h12]}, 64'h00);
        chk("rstw_m13", {56'd0, tmem[8'h13]}, 64'h00);
        do_fetch(8'h10, 32'h00003344);

        // Back-to-back fetches
        do_load(8'h04, 32'hA1B2C3D4);
        do_load(8'h08, 32'h0BADF00D);
        tbl[0] = 32'h0050DEAD;
        tbl[1] = 32'hA1B2C3D4;
        tbl[2] = 32'h0BADF00D;
        held = 32'h00003344;
        f_req = 1'b1; f_addr = 8'h00; #1;
        nv = 0; ngf = 0; last_g = 0;
        for (int c = 0; c < 60 && nv < 3; c++) begin
            if (f_valid) begin
                chk("b2b_instr", {32'd0, f_instr}, {32'd0, tbl[nv]});
                if (nv < 2) chk("b2b_valid_gnt", {63'd0, f_gnt}, 64'd1);
                held = tbl[nv];
                nv++;
            end else begin
                chk("b2b_stable", {32'd0, f_instr}, {32'd0, held});
            end
            chk("b2b_no_lgnt", {63'd0, l_gnt}, 64'd0);
            gflag = f_gnt;
            if (f_gnt) begin
                if (ngf > 0) chk("b2b_gap", 64'(c - last_g), 64'd6);
                last_g = c;
                ngf++;
            end
            tick;
            if (gflag) begin
                f_addr = 8'(4 * ngf);
                if (ngf == 3) f_req = 1'b0;
            end
            #1;
        end
        chk("b2b_count", 64'(nv), 64'd3);
        chk("b2b_gnts", 64'(ngf), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequencer and arbiter for the 256-byte, byte-wide instruction memory. It shares the single memory port between the fetch stage and the program loader. Fetches are serviced as four little-endian byte reads assembled into one 32-bit instruction. Loader writes are split into four byte writes. Sits between the IF stage and the byte-array memory, and replaces direct combinational word access once the memory becomes a single-port synchronous macro.

## Interface
- ADDR_W, 8, byte address width; memory depth is 2**ADDR_W bytes.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; f_addr held stable while high
- f_addr  in  ADDR_W  fetch byte address (any alignment)
- f_gnt  out  1  one-cycle pulse: fetch accepted, f_addr latched
- f_valid  out  1  one-cycle pulse: f_instr holds the new instruction
- f_instr  out  32  assembled instruction {b3,b2,b1,b0}; held until the next f_valid
- l_req  in  1  loader write request; l_addr and l_wdata held stable while high
- l_addr  in  ADDR_W  loader byte address
- l_wdata  in  32  word to write, little-endian
- l_gnt  out  1  one-cycle pulse: write accepted, l_addr and l_wdata latched
- l_done  out  1  one-cycle pulse: all four bytes committed
- mem_addr  out  ADDR_W  memory byte address
- mem_we  out  1  byte write enable
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte; valid the cycle after mem_addr is presented with mem_we=0
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RD0–RD3, RWAIT, WR0–WR3.
- IDLE:
  - If any request is present, grant one requester this cycle. f_gnt and l_gnt are combinational from state and the req inputs.
  - Latch the base address (and wdata for writes).
  - Go to RD0 for a fetch, WR0 for a load.
- Arbitration:
  - A single requester always wins.
  - When both request, use round-robin on a last_grant flag.
  - last_grant resets to "fetch", so the loader wins the first tie after reset.
- RDk (k=0..3): mem_addr = base+k, mem_we=0. In RD1–RD3 and RWAIT, capture mem_rdata into byte k-1.
- RWAIT: capture byte 3, then go to IDLE. f_valid pulses in the first IDLE cycle with f_instr updated.
- WRk: mem_addr = base+k, mem_we=1, mem_wdata = wdata[8k+7:8k]. After WR3, go to IDLE; l_done pulses in that IDLE cycle.
- Address arithmetic is modulo 2**ADDR_W, so base+k wraps (0xFF+1 = 0x00). Unaligned bases are legal.
- mem_addr, mem_we and mem_wdata are driven from registers only, with no combinational path from f_*/l_* inputs. In IDLE they are 0.
- A request deasserted before grant is dropped silently. A request change after grant has no effect on the current operation.
- Reset, including mid-operation:
  - All outputs go to 0, f_instr goes to 0x00000000, and state goes to IDLE on the next edge.
  - A write in progress is abandoned: bytes already committed remain, and no l_done is issued.
  - A read in progress produces no f_valid.

## Timing
- Grant at cycle T; the operation's first memory cycle is T+1.
- Fetch:
  - Addresses are issued T+1..T+4.
  - Bytes arrive T+2..T+5.
  - f_valid is at T+6.
  - Latency from grant to data is 6 cycles.
- Write:
  - Bytes are committed at the edges ending T+1..T+4.
  - l_done is at T+5.
- The cycle carrying f_valid or l_done is IDLE, so a new grant may occur in that same cycle.
- Sustained throughput: one fetch per 6 cycles, one load per 5 cycles.
- f_gnt and l_gnt are never high together. At most one of f_valid and l_done is high in any cycle.

## Test plan
- Load then fetch:
  - Load 0x00500093 at 0x00 → bytes 93, 00, 50, 00 written to addresses 0..3 in T+1..T+4, l_done at T+5.
  - Then fetch 0x00 → f_instr = 0x00500093, f_valid 6 cycles after f_gnt.
- Wrap-around:
  - Load 0xDEADBEEF at 0xFE → EF@FE, BE@FF, AD@00, DE@01.
  - Fetch 0xFE → 0xDEADBEEF.
- Arbitration:
  - f_req and l_req both held from reset release → grant order is l, f, l, f.
  - Fetch only → every grant goes to f.
  - No overlapping gnt/valid/done pulses.
- Reset mid-write:
  - Load 0x11223344 at 0x10, assert rst during WR1 → only 0x10 = 44 and 0x11 = 33 are changed.
  - No l_done; all outputs are 0 next cycle; a subsequent fetch works normally.
- Back-to-back fetch:
  - f_req held with f_addr stepping 0, 4, 8 → f_gnt every 6 cycles.
  - Each f_valid coincides with the next f_gnt.
  - f_instr is stable between f_valid pulses.
